// File: rtl/rfft_loader.sv
// Front-end loader for the 256-point radix-4 RFFT core: packs real samples into
// complex words, scatters them over four banks, then hands the banks to the core.
module rfft_loader #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 16,
  parameter int N        = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_last,
  output logic [3:0]          bank_we,
  output logic [5:0]          bank_addr,
  output logic [WIDTH-1:0]    bank_data,
  output logic                bank_sel,
  output logic                fft_run,
  input  logic                fft_done,
  output logic                frame_done,
  output logic                err
);

  localparam int               CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic [3:0]         bank_we_q, bank_we_d;
  logic [5:0]         bank_addr_q, bank_addr_d;
  logic [WIDTH-1:0]   bank_data_q, bank_data_d;
  logic               bank_sel_q, bank_sel_d;
  logic               fft_run_q, fft_run_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;
  logic               accept;

  // Quarters 1 and 2 are swapped so the core's first stage reads samples a, a+64, a+128, a+192
  // from banks 0, 2, 1, 3 at the same address.
  function automatic logic [3:0] bank_onehot(input logic [1:0] quarter);
    return 4'b0001 << {quarter[0], quarter[1]};
  endfunction

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready_d   = in_ready_q;
    bank_we_d    = 4'b0000;
    bank_addr_d  = bank_addr_q;
    bank_data_d  = bank_data_q;
    bank_sel_d   = bank_sel_q;
    fft_run_d    = fft_run_q;
    frame_done_d = 1'b0;
    err_d        = err_q;

    case (state_q)
      LOAD: begin
        in_ready_d = 1'b1;
        bank_sel_d = 1'b1;
        if (accept) begin
          bank_we_d   = bank_onehot(cnt_q[CNT_W-1 -: 2]);
          bank_addr_d = cnt_q[5:0];
          bank_data_d = {in_data, {IN_WIDTH{1'b0}}};
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d    = RUN;
            in_ready_d = 1'b0;
            if (!in_last) begin
              err_d = 1'b1;
            end
          end else if (in_last) begin
            state_d    = FILL;
            in_ready_d = 1'b0;
            err_d      = 1'b1;
          end
        end
      end

      FILL: begin
        in_ready_d  = 1'b0;
        bank_we_d   = bank_onehot(cnt_q[CNT_W-1 -: 2]);
        bank_addr_d = cnt_q[5:0];
        bank_data_d = '0;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // The first RUN cycle only hands the banks over; the core may finish from the next one on.
        in_ready_d = 1'b0;
        if (!fft_run_q) begin
          fft_run_d  = 1'b1;
          bank_sel_d = 1'b0;
        end else if (fft_done) begin
          fft_run_d    = 1'b0;
          frame_done_d = 1'b1;
          bank_sel_d   = 1'b1;
          cnt_d        = '0;
          state_d      = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      bank_we_q    <= 4'b0000;
      bank_addr_q  <= 6'd0;
      bank_data_q  <= '0;
      bank_sel_q   <= 1'b1;
      fft_run_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_data_q  <= bank_data_d;
      bank_sel_q   <= bank_sel_d;
      fft_run_q    <= fft_run_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_data  = bank_data_q;
  assign bank_sel   = bank_sel_q;
  assign fft_run    = fft_run_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rfft_loader.sv
// Bench for rfft_loader: a frame-level reference model predicts every registered output each
// cycle, and the banks written by the DUT are captured to pin hand-computed word placements.
module tb_rfft_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [3:0]  bank_we;
  logic [5:0]  bank_addr;
  logic [31:0] bank_data;
  logic        bank_sel;
  logic        fft_run;
  logic        fft_done;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int passed = 0;

  rfft_loader #(.WIDTH(32), .IN_WIDTH(16), .N(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .bank_we   (bank_we),
    .bank_addr (bank_addr),
    .bank_data (bank_data),
    .bank_sel  (bank_sel),
    .fft_run   (fft_run),
    .fft_done  (fft_done),
    .frame_done(frame_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what each output must read during the coming cycle
  localparam int PH_ACCEPT  = 0;
  localparam int PH_PAD     = 1;
  localparam int PH_HANDOFF = 2;
  localparam int PH_WAIT    = 3;

  int          bank_order [4] = '{0, 2, 1, 3};
  int          phase;
  int          m_idx;
  logic        m_ready;
  logic [3:0]  m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_data;
  logic        m_sel;
  logic        m_run;
  logic        m_fdone;
  logic        m_err;

  logic [31:0] dut_mem [4][64];
  int          writes_seen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    phase   = PH_ACCEPT;
    m_idx   = 0;
    m_ready = 1'b0;
    m_we    = 4'b0000;
    m_addr  = 6'd0;
    m_data  = 32'h0;
    m_sel   = 1'b1;
    m_run   = 1'b0;
    m_fdone = 1'b0;
    m_err   = 1'b0;
  endtask

  // Sample index i sits in quarter i/64 at address i%64; quarters map to banks 0,2,1,3
  task automatic modelWrite(input int idx, input logic [15:0] d);
    m_we   = 4'b0001 << bank_order[idx / 64];
    m_addr = 6'(idx % 64);
    m_data = {d, 16'h0000};
  endtask

  task automatic modelStep();
    logic took;
    took    = in_valid && m_ready;
    m_we    = 4'b0000;
    m_fdone = 1'b0;
    case (phase)
      PH_ACCEPT: begin
        m_ready = 1'b1;
        if (took) begin
          modelWrite(m_idx, in_data);
          m_idx++;
          if (m_idx == 256) begin
            phase   = PH_HANDOFF;
            m_ready = 1'b0;
            if (!in_last) m_err = 1'b1;
          end else if (in_last) begin
            phase   = PH_PAD;
            m_ready = 1'b0;
            m_err   = 1'b1;
          end
        end
      end
      PH_PAD: begin
        modelWrite(m_idx, 16'h0000);
        m_idx++;
        if (m_idx == 256) phase = PH_HANDOFF;
      end
      PH_HANDOFF: begin
        m_run = 1'b1;
        m_sel = 1'b0;
        phase = PH_WAIT;
      end
      default: begin
        if (fft_done) begin
          m_run   = 1'b0;
          m_fdone = 1'b1;
          m_sel   = 1'b1;
          m_idx   = 0;
          phase   = PH_ACCEPT;
        end
      end
    endcase
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) modelReset();
      else modelStep();
    end
  end

  // Compare process: all outputs every cycle, address/data whenever a write is due
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("in_ready", 32'(in_ready), 32'(m_ready));
      checkOutput("bank_we", 32'(bank_we), 32'(m_we));
      checkOutput("bank_sel", 32'(bank_sel), 32'(m_sel));
      checkOutput("fft_run", 32'(fft_run), 32'(m_run));
      checkOutput("frame_done", 32'(frame_done), 32'(m_fdone));
      checkOutput("err", 32'(err), 32'(m_err));
      if (m_we != 4'b0000) begin
        checkOutput("bank_addr", 32'(bank_addr), 32'(m_addr));
        checkOutput("bank_data", bank_data, m_data);
      end
      if (bank_we != 4'b0000) writes_seen++;
      for (int b = 0; b < 4; b++) begin
        if (bank_we[b]) dut_mem[b][bank_addr] = bank_data;
      end
    end
  end

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_data = 16'($urandom);
      in_last = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  // Present one sample after `gap` idle cycles and hold it until the loader takes it
  task automatic applyStimulus(input logic [15:0] d, input logic last, input int gap);
    logic ok;
    int   guard;
    idleCycles(gap);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok       = 1'b0;
    guard    = 0;
    while (!ok && guard < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitFrameDone(input int hold, input string tag);
    logic seen;
    int   guard;
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    fft_done = 1'b1;
    seen     = 1'b0;
    guard    = 0;
    while (!seen && guard < 100) begin
      @(negedge clk);
      seen = frame_done;
      guard++;
      if (!seen) begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
    fft_done = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_bank_we"}, 32'(bank_we), 32'd0);
    checkOutput({tag, "_bank_addr"}, 32'(bank_addr), 32'd0);
    checkOutput({tag, "_bank_data"}, bank_data, 32'd0);
    checkOutput({tag, "_bank_sel"}, 32'(bank_sel), 32'd1);
    checkOutput({tag, "_fft_run"}, 32'(fft_run), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    in_last  = 1'b0;
    fft_done = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 64; a++) dut_mem[b][a] = 32'hDEAD_BEEF;

    #12;
    checkResetValues("reset");
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // Single frame, continuous valid, then a long wait for the core
    $display("[TB] frame 1: continuous 0..255");
    writes_seen = 0;
    for (int n = 0; n < 256; n++) applyStimulus(16'(n), n == 255, 0);
    checkOutput("f1_run_not_yet", 32'(fft_run), 32'd0);
    in_valid = 1'b1;
    waitFrameDone(500, "f1");
    in_valid = 1'b0;
    checkOutput("f1_writes", 32'(writes_seen), 32'd256);
    checkOutput("f1_s64", dut_mem[2][0], 32'h0040_0000);
    checkOutput("f1_s130", dut_mem[1][2], 32'h0082_0000);
    checkOutput("f1_s255", dut_mem[3][63], 32'h00FF_0000);
    checkOutput("f1_s1", dut_mem[0][1], 32'h0001_0000);
    checkOutput("f1_err", 32'(err), 32'd0);

    // Random gaps, negative samples, core already done when RUN starts
    $display("[TB] frame 2: 50%% valid gaps");
    writes_seen = 0;
    fft_done    = 1'b1;
    for (int n = 0; n < 256; n++) applyStimulus(16'(16'hFF00 + n), n == 255, int'($urandom_range(0, 1)));
    waitFrameDone(0, "f2");
    checkOutput("f2_writes", 32'(writes_seen), 32'd256);
    checkOutput("f2_s0", dut_mem[0][0], 32'hFF00_0000);
    checkOutput("f2_s200", dut_mem[3][8], 32'hFFC8_0000);

    // Early last on the 100th sample: zero padding of indices 100..255
    $display("[TB] frame 3: early last");
    writes_seen = 0;
    for (int n = 0; n < 100; n++) applyStimulus(16'(n), n == 99, 0);
    checkOutput("f3_err", 32'(err), 32'd1);
    checkOutput("f3_ready_low", 32'(in_ready), 32'd0);
    repeat (156) begin
      @(posedge clk);
      #1;
    end
    checkOutput("f3_run_after_fill", 32'(fft_run), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("f3_run", 32'(fft_run), 32'd1);
    waitFrameDone(3, "f3");
    checkOutput("f3_writes", 32'(writes_seen), 32'd256);
    checkOutput("f3_s99", dut_mem[2][35], 32'h0063_0000);
    checkOutput("f3_s100", dut_mem[2][36], 32'h0000_0000);
    checkOutput("f3_s255", dut_mem[3][63], 32'h0000_0000);

    // Missing last: error on the 256th accept, nothing taken while the core runs
    $display("[TB] frame 4: missing last");
    doReset();
    writes_seen = 0;
    for (int n = 0; n < 256; n++) applyStimulus(16'(n), 1'b0, 0);
    checkOutput("f4_err", 32'(err), 32'd1);
    checkOutput("f4_run_pre", 32'(fft_run), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h7777;
    @(posedge clk);
    #1;
    checkOutput("f4_run", 32'(fft_run), 32'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("f4_no_extra", 32'(writes_seen), 32'd256);
    waitFrameDone(0, "f4");

    // Reset in the middle of a load, then a clean frame
    $display("[TB] frame 5: reset mid-load");
    doReset();
    for (int n = 0; n < 37; n++) applyStimulus(16'(n + 256), 1'b0, 0);
    #2 reset = 1'b1;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    writes_seen = 0;
    for (int n = 0; n < 256; n++) applyStimulus(16'(n + 512), n == 255, 0);
    waitFrameDone(2, "f5");
    checkOutput("f5_writes", 32'(writes_seen), 32'd256);
    checkOutput("f5_s0", dut_mem[0][0], 32'h0200_0000);
    checkOutput("f5_s36", dut_mem[0][36], 32'h0224_0000);
    checkOutput("f5_err", 32'(err), 32'd0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
